// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB-first, odd parity, stop bit(s).
// Bit timing comes from an internal baud counter running on clk2.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk2,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       busy,
    output logic       done_t
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0] NSTOP = 2'(STOP_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [1:0]    r_stop;
    logic          r_tx;
    logic          r_busy;
    logic          r_done;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign tx     = r_tx;
    assign busy   = r_busy;
    assign done_t = r_done;

    // tx is updated together with the state so it only moves at bit boundaries
    always_ff @(posedge clk2) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_stop  <= 2'd1;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt  <= '0;
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (tx_start) begin
                        r_shift <= tx_data;
                        r_par   <= ~^tx_data;
                        r_idx   <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_wrap) begin
                        r_cnt   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_wrap) begin
                        r_cnt   <= '0;
                        r_shift <= r_shift >> 1;
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_tx    <= r_par;
                            r_state <= PARITY;
                        end else begin
                            r_tx <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (w_wrap) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_stop  <= 2'd1;
                        r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_wrap) begin
                        r_cnt <= '0;
                        if (r_stop == NSTOP) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_stop <= r_stop + 2'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: two instances cover
// 4 clk/bit with one stop bit and 3 clk/bit with two stop bits.
module tb_uart_transmitter;

    logic       clk2 = 1'b0;
    logic       rst;
    logic       start_a;
    logic       start_b;
    logic [7:0] tx_data;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;
    bit         sel;
    logic       w_tx, w_busy, w_done;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk2 = ~clk2;

    uart_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_a (
        .clk2(clk2), .rst(rst), .tx_start(start_a), .tx_data(tx_data),
        .tx(tx_a), .busy(busy_a), .done_t(done_a)
    );

    uart_transmitter #(.CLKS_PER_BIT(3), .STOP_BITS(2)) u_b (
        .clk2(clk2), .rst(rst), .tx_start(start_b), .tx_data(tx_data),
        .tx(tx_b), .busy(busy_b), .done_t(done_b)
    );

    assign w_tx   = sel ? tx_b   : tx_a;
    assign w_busy = sel ? busy_b : busy_a;
    assign w_done = sel ? done_b : done_a;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int k,
                                     input int c);
        int b;
        b = k / c;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9) return ~^d;
        return 1'b1;
    endfunction

    // Called in the first cycle after the accepting edge; returns in the
    // done cycle (or early at stop_k). inj_k fires a stray request on A.
    task automatic frame(input string tag, input logic [7:0] d,
                         input int c, input int sb,
                         input int inj_k, input int stop_k);
        int f;
        f = (10 + sb) * c;
        for (int k = 0; k < f; k++) begin
            if (k == stop_k) return;
            chk({tag, "_tx"}, 32'(w_tx), 32'(exp_bit(d, k, c)));
            chk({tag, "_busy"}, 32'(w_busy), 32'd1);
            chk({tag, "_done"}, 32'(w_done), 32'd0);
            if (k == inj_k) begin
                start_a = 1'b1;
                tx_data = 8'h3C;
            end else if (k == inj_k + 1) begin
                start_a = 1'b0;
            end
            @(negedge clk2);
        end
        chk({tag, "_end_done"}, 32'(w_done), 32'd1);
        chk({tag, "_end_busy"}, 32'(w_busy), 32'd0);
        chk({tag, "_end_tx"}, 32'(w_tx), 32'd1);
    endtask

    task automatic req_a(input logic [7:0] d);
        start_a = 1'b1;
        tx_data = d;
        @(negedge clk2);
        start_a = 1'b0;
    endtask

    task automatic idle_chk(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_tx"}, 32'(w_tx), 32'd1);
            chk({tag, "_busy"}, 32'(w_busy), 32'd0);
            chk({tag, "_done"}, 32'(w_done), 32'd0);
            @(negedge clk2);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        tx_data = 8'h00;
        sel     = 1'b0;
        @(negedge clk2);
        @(negedge clk2);
        chk("rst_tx", 32'(tx_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        rst = 1'b0;
        @(negedge clk2);

        idle_chk("idle", 20);

        req_a(8'hA5);
        frame("a5", 8'hA5, 4, 1, -1, -1);
        @(negedge clk2);
        idle_chk("a5_after", 2);

        req_a(8'h01);
        frame("b2b01", 8'h01, 4, 1, -1, -1);
        req_a(8'hFF);
        frame("b2bFF", 8'hFF, 4, 1, -1, -1);
        @(negedge clk2);
        idle_chk("ff_after", 2);

        req_a(8'hA5);
        frame("ign", 8'hA5, 4, 1, 10, -1);
        @(negedge clk2);
        idle_chk("ign_after", 10);

        req_a(8'hA5);
        frame("abort", 8'hA5, 4, 1, -1, 37);
        rst = 1'b1;
        @(negedge clk2);
        chk("abort_tx", 32'(tx_a), 32'd1);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_done", 32'(done_a), 32'd0);
        rst = 1'b0;
        @(negedge clk2);
        idle_chk("abort_after", 12);

        req_a(8'h55);
        frame("f55", 8'h55, 4, 1, -1, -1);
        @(negedge clk2);

        sel     = 1'b1;
        start_b = 1'b1;
        tx_data = 8'h00;
        @(negedge clk2);
        start_b = 1'b0;
        frame("sb2", 8'h00, 3, 2, -1, -1);
        @(negedge clk2);
        idle_chk("sb2_after", 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serial UART transmitter that frames one byte per request as start bit, 8 data bits LSB-first, odd parity bit, then stop bit(s). It is the transmit-side counterpart of the team's UART receiver and uses the same frame format. The receiver's parity check flags no error only when the XOR of the data and the parity bit equals 1. The block runs on system clock clk2 and derives its bit timing from an internal baud counter. It sits between the host-side byte source and the serial line.

Parameters:
CLKS_PER_BIT, 16, clk2 cycles per serial bit period; legal range 2..65535.
STOP_BITS, 1, number of stop-bit periods; legal values 1 or 2.

Ports:
clk2  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
tx_start  input  1  request to send tx_data; sampled every clk2 edge.
tx_data  input  8  byte to transmit; captured only when a request is accepted.
tx  output  1  serial line; idles high.
busy  output  1  high while a frame is in progress.
done_t  output  1  single-cycle pulse at end of frame.

Behaviour:
- Reset, rst=1 at a clk2 edge:
  - state=IDLE, tx=1, busy=0, done_t=0.
  - Baud counter, bit index and shift register cleared.
  - Reset mid-frame aborts the frame immediately: tx returns high on the next edge, and no done_t is generated.
- Acceptance:
  - A request is accepted at edge N when tx_start=1 and state=IDLE.
  - tx_data is latched into the shift register at edge N.
  - Odd parity is computed at edge N: parity = ~^tx_data.
  - tx_start while busy=1 is ignored; it is neither queued nor able to alter the latched data.
- States and transitions:
  - IDLE: tx=1, busy=0. On acceptance, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0]; each bit held for CLKS_PER_BIT cycles, shift right by 1 after each bit. After bit index 7 completes, go to PARITY.
  - PARITY: tx=parity for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Timing from acceptance edge N:
  - tx and busy change at edge N+1 (registered outputs).
  - Frame occupies cycles N+1 .. N+F, where F=(10+STOP_BITS)*CLKS_PER_BIT.
  - At edge N+F+1: state=IDLE, busy=0, done_t=1 for exactly one cycle.
- Back-to-back operation:
  - tx_start=1 in the done_t cycle (state already IDLE) is accepted.
  - The next start bit begins one cycle later, so idle-high lasts at least one clk2 cycle between frames.
  - If tx_start is held high continuously, frames repeat with data sampled at each acceptance.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps; wrap marks a bit boundary.
  - Reloaded to 0 on acceptance and on every state change.
- Bit index: 3 bits, wraps 7->0 when leaving DATA.
- Stop counter: counts stop-bit periods 1..STOP_BITS.
- Outputs: all registered; tx is glitch-free, changing only at bit boundaries.
- Simultaneous rst and tx_start: rst wins and the request is dropped.
- Unused state encodings: recover to IDLE with tx=1.

Test Plan:
1. Reset with CLKS_PER_BIT=4, STOP_BITS=1, then hold 20 cycles idle -> tx=1, busy=0, done_t=0 throughout.
2. Pulse tx_start with tx_data=0xA5 -> tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1(parity),1(stop); busy high for 44 cycles; done_t single pulse at cycle 45.
3. Send 0x01, then 0xFF back-to-back by asserting tx_start in the done_t cycle -> parity bits 0 and 1 respectively; exactly one idle-high cycle between frames.
4. Assert tx_start with tx_data=0x3C mid-frame of 0xA5, in the DATA state -> ignored; 0xA5 frame bits unchanged; no second frame.
5. Assert rst during the PARITY state -> tx=1 and busy=0 on the next edge; no done_t; a subsequent 0x55 request frames correctly.
6. Set STOP_BITS=2, CLKS_PER_BIT=3, send 0x00 -> start 0, eight 0s, parity 1, tx high for 6 cycles; busy for 36 cycles; done_t at cycle 37.
